// File: rtl/gpio_atr_pkg.sv
// ============================================================================
// Module   : gpio_atr_pkg
// Purpose  : Shared state encodings, slot offsets and the masked-write helper
//            for the GPIO ATR controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_atr_pkg;

    localparam int unsigned c_DLY_W_DEFAULT  = 12;
    localparam int unsigned c_NUM_BANKS      = 4;
    localparam int unsigned c_SLOTS_PER_BANK = 4;

    // Register offset of the delay word, relative to ADDR_BASE
    localparam logic [6:0] c_DLY_OFFSET = 7'd16;

    localparam logic [1:0] c_SLOT_IDLE = 2'd0;
    localparam logic [1:0] c_SLOT_RX   = 2'd1;
    localparam logic [1:0] c_SLOT_TX   = 2'd2;
    localparam logic [1:0] c_SLOT_FDX  = 2'd3;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_RX      = 3'd1;
    localparam logic [2:0] c_ST_TX_WAIT = 3'd2;
    localparam logic [2:0] c_ST_TX      = 3'd3;
    localparam logic [2:0] c_ST_RX_WAIT = 3'd4;

    // Upper half of the bus word selects which bits of the lower half land
    function automatic logic [15:0] masked_write(input logic [15:0] old_val,
                                                 input logic [31:0] data);
        return (old_val & ~data[31:16]) | (data[15:0] & data[31:16]);
    endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_atr_bank.sv
// ============================================================================
// Module   : gpio_atr_bank
// Purpose  : One GPIO bank's four masked value registers (idle/rx/tx/fdx)
//            and the slot-select mux feeding the controller's output register.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_atr_bank
    import gpio_atr_pkg::*;
#(
    parameter logic [6:0] BANK_ADDR = 7'd48
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [6:0]  i_serial_addr,
    input  logic [31:0] i_serial_data,
    input  logic        i_serial_strobe,
    input  logic [1:0]  i_sel,
    output logic [15:0] o_value
);

    logic [15:0] r_slot [c_SLOTS_PER_BANK];

    for (genvar s = 0; s < c_SLOTS_PER_BANK; s++) begin : g_slot
        localparam logic [6:0] c_SLOT_ADDR = BANK_ADDR + 7'(s);

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_slot[s] <= '0;
            end else if (i_serial_strobe && (i_serial_addr == c_SLOT_ADDR)) begin
                r_slot[s] <= masked_write(r_slot[s], i_serial_data);
            end
        end
    end

    assign o_value = r_slot[i_sel];

endmodule

`default_nettype wire

// File: rtl/gpio_atr_ctrl.sv
// ============================================================================
// Module   : gpio_atr_ctrl
// Purpose  : ATR state machine with optional TX/RX turnaround delays driving
//            the four daughterboard GPIO bank values.
//            Build option: GPIO_ATR_DELAY_EN enables the delay register,
//            the turnaround counter and the TX_WAIT/RX_WAIT states.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_atr_ctrl
    import gpio_atr_pkg::*;
#(
    parameter logic [6:0] ADDR_BASE = 7'd48,
    parameter int         DLY_W     = c_DLY_W_DEFAULT
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    input  logic        tx_enable,
    input  logic        rx_enable,
    output logic [15:0] atr_0,
    output logic [15:0] atr_1,
    output logic [15:0] atr_2,
    output logic [15:0] atr_3,
    output logic [2:0]  atr_state
);

    // Each delay field sits inside one 16-bit half of the delay word
    if (DLY_W < 1 || DLY_W > 16) begin : g_dly_w_check
        $error("gpio_atr_ctrl: DLY_W must be in 1..16");
    end

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [1:0]  w_slot;
    logic [15:0] w_bank_val [c_NUM_BANKS];
    logic [15:0] r_atr      [c_NUM_BANKS];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

`ifdef GPIO_ATR_DELAY_EN
    logic [DLY_W-1:0] r_tx_delay;
    logic [DLY_W-1:0] r_rx_delay;
    logic [DLY_W-1:0] r_count;
    logic [DLY_W-1:0] w_next_count;
    logic [DLY_W-1:0] w_tx_start_count;
    logic [2:0]       w_tx_start_state;
    logic             w_dly_write;

    assign w_dly_write = serial_strobe && (serial_addr == ADDR_BASE + c_DLY_OFFSET);

    // The running count is loaded once on entry, so later delay writes
    // only affect the next wait.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_tx_delay <= '0;
            r_rx_delay <= '0;
            r_count    <= '0;
        end else begin
            r_count <= w_next_count;
            if (w_dly_write) begin
                r_tx_delay <= serial_data[DLY_W-1:0];
                r_rx_delay <= serial_data[16+DLY_W-1:16];
            end
        end
    end

    always_comb begin
        w_tx_start_state = (r_tx_delay == '0) ? c_ST_TX : c_ST_TX_WAIT;
        w_tx_start_count = r_tx_delay;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        case (r_state)
            c_ST_IDLE: begin
                if (tx_enable) begin
                    w_next_state = w_tx_start_state;
                    w_next_count = w_tx_start_count;
                end else if (rx_enable) begin
                    w_next_state = c_ST_RX;
                end
            end
            c_ST_RX: begin
                if (tx_enable) begin
                    w_next_state = w_tx_start_state;
                    w_next_count = w_tx_start_count;
                end else if (!rx_enable) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_TX_WAIT: begin
                if (!tx_enable) begin
                    w_next_state = c_ST_IDLE;
                    w_next_count = '0;
                end else if (r_count == DLY_W'(1)) begin
                    w_next_state = c_ST_TX;
                    w_next_count = '0;
                end else begin
                    w_next_count = r_count - DLY_W'(1);
                end
            end
            c_ST_TX: begin
                if (!tx_enable) begin
                    if (r_rx_delay != '0) begin
                        w_next_state = c_ST_RX_WAIT;
                        w_next_count = r_rx_delay;
                    end else begin
                        w_next_state = rx_enable ? c_ST_RX : c_ST_IDLE;
                    end
                end
            end
            c_ST_RX_WAIT: begin
                if (tx_enable) begin
                    w_next_state = w_tx_start_state;
                    w_next_count = w_tx_start_count;
                end else if (r_count == DLY_W'(1)) begin
                    w_next_state = rx_enable ? c_ST_RX : c_ST_IDLE;
                    w_next_count = '0;
                end else begin
                    w_next_count = r_count - DLY_W'(1);
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
                w_next_count = '0;
            end
        endcase
    end
`else
    // ------------------------------------------------------------------
    // Next-state logic (no turnaround delays)
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (tx_enable) begin
                    w_next_state = c_ST_TX;
                end else if (rx_enable) begin
                    w_next_state = c_ST_RX;
                end
            end
            c_ST_RX: begin
                if (tx_enable) begin
                    w_next_state = c_ST_TX;
                end else if (!rx_enable) begin
                    w_next_state = c_ST_IDLE;
                end
            end
            c_ST_TX: begin
                if (!tx_enable) begin
                    w_next_state = rx_enable ? c_ST_RX : c_ST_IDLE;
                end
            end
            default: begin
                w_next_state = c_ST_IDLE;
            end
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Output select, driven from the next state so the value register
    // lines up with the state register.
    // ------------------------------------------------------------------
    always_comb begin
        w_slot = c_SLOT_IDLE;
        case (w_next_state)
            c_ST_RX: w_slot = c_SLOT_RX;
            c_ST_TX: w_slot = rx_enable ? c_SLOT_FDX : c_SLOT_TX;
            default: w_slot = c_SLOT_IDLE;
        endcase
    end

    for (genvar b = 0; b < c_NUM_BANKS; b++) begin : g_bank
        gpio_atr_bank #(
            .BANK_ADDR (ADDR_BASE + 7'(c_SLOTS_PER_BANK * b))
        ) u_bank (
            .clock           (clock),
            .reset_n         (reset_n),
            .i_serial_addr   (serial_addr),
            .i_serial_data   (serial_data),
            .i_serial_strobe (serial_strobe),
            .i_sel           (w_slot),
            .o_value         (w_bank_val[b])
        );

        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_atr[b] <= '0;
            end else begin
                r_atr[b] <= w_bank_val[b];
            end
        end
    end

    assign atr_0     = r_atr[0];
    assign atr_1     = r_atr[1];
    assign atr_2     = r_atr[2];
    assign atr_3     = r_atr[3];
    assign atr_state = r_state;

endmodule

`default_nettype wire
